alu_issue_ctrl: RTL and testbench

Upstream issue/retire controller for the 3-stage pipelined ALU (ALU output latency: result/c/v 2 edges after operand sampling, z/n 3 edges after).
- Accepts operations over a valid/ready handshake and drives ALU operands and opcode through registers.
- Tracks in-flight ops with a valid/tag shift pipe and realigns result with all four flags.
- Buffers completed results in an output FIFO with credit-based backpressure, so no ALU result is ever dropped.

---
 rtl/alu_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/retire controller in front of a 3-stage pipelined ALU.
//
// Purpose:
//   Accepts ops over a valid/ready handshake and registers the operands and
//   opcode into the ALU. A 5-deep valid/tag pipe follows each op through the
//   ALU. result/c/v are captured one edge before z/n so that all four flags
//   line up. Completed results go into a small circular FIFO. Credit-based
//   admission keeps the FIFO from ever overflowing.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        op request handshake
//   in_a, in_b, in_op        operands and opcode
//   in_tag                   user tag carried with the op
//   alu_a, alu_b, alu_op     registered drive into the ALU
//   alu_result, alu_c/v      ALU outputs, valid 2 edges after operand sampling
//   alu_z, alu_n             ALU flags, valid 3 edges after operand sampling
//   out_valid/out_ready      FIFO head handshake
//   out_result, out_c/v/z/n  head entry data
//   out_tag                  head entry tag
//   busy                     an op is in flight or the FIFO is non-empty
module alu_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 3;

  logic [4:0]       pv;
  logic [TAG_W-1:0] pt [0:4];

  logic [WIDTH-1:0] align_result;
  logic             align_c;
  logic             align_v;

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [3:0]       mem_f [0:DEPTH-1];   // {c, v, z, n}
  logic [TAG_W-1:0] mem_t [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             accept;
  logic             push;
  logic             pop;
  logic [2:0]       inflight;
  logic [SW-1:0]    credit;

  assign accept = in_valid & in_ready;
  assign push   = pv[4];
  assign pop    = out_valid & out_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < 5; i++) inflight = inflight + {2'b00, pv[i]};
  end

  // Every op already in the pipe is given a FIFO slot when it is admitted,
  // so a push can never meet a full FIFO. This uses registered state only.
  assign credit   = SW'(count) + SW'(inflight);
  assign in_ready = credit < SW'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 3'b111;
    end else if (accept) begin
      alu_a  <= in_a;
      alu_b  <= in_b;
      alu_op <= in_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < 5; i++) pt[i] <= '0;
    end else begin
      pv    <= {pv[3:0], accept};
      pt[0] <= in_tag;
      for (int i = 1; i < 5; i++) pt[i] <= pt[i-1];
    end
  end

  // result/c/v are valid one cycle before z/n, so hold them for one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_result <= '0;
      align_c      <= 1'b0;
      align_v      <= 1'b0;
    end else if (pv[3]) begin
      align_result <= alu_result;
      align_c      <= alu_c;
      align_v      <= alu_v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
        mem_f[i] <= '0;
        mem_t[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr] <= align_result;
        mem_f[wr_ptr] <= {align_c, align_v, alu_z, alu_n};
        mem_t[wr_ptr] <= pt[4];
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid  = (count != '0);
  assign out_result = mem_r[rd_ptr];
  assign out_c      = mem_f[rd_ptr][3];
  assign out_v      = mem_f[rd_ptr][2];
  assign out_z      = mem_f[rd_ptr][1];
  assign out_n      = mem_f[rd_ptr][0];
  assign out_tag    = mem_t[rd_ptr];
  assign busy       = (|pv) | out_valid;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c, alu_v, alu_z, alu_n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_c, out_v, out_z, out_n;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_pass = 0;
  int n_total = 0;

  // out_ready source: 0 = low, 1 = high, 2 = random each cycle
  int   ready_mode = 0;
  logic rnd_bit = 1'b0;
  assign out_ready = (ready_mode == 2) ? rnd_bit : (ready_mode == 1);

  // entry = {result, c, v, z, n, tag}
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          max_cnt = 0;
  int          full_push_seen = 0;
  int          out_valid_seen = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v),
    .alu_z(alu_z), .alu_n(alu_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_c(out_c), .out_v(out_v),
    .out_z(out_z), .out_n(out_n), .out_tag(out_tag),
    .busy(busy)
  );

  // Opcodes: 000 ADD, 001 SUB (c = borrow), 010 AND, 011 OR, 100 XOR, else pass A.
  // Returns {result, c, v}.
  function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    int   sa, sb, sr;
    logic [7:0] r;
    logic c, v;
    sa = (a > 127) ? int'(a) - 256 : int'(a);
    sb = (b > 127) ? int'(b) - 256 : int'(b);
    c = 1'b0; v = 1'b0;
    case (op)
      3'b000: begin
        r = 8'((int'(a) + int'(b)) % 256);
        c = (int'(a) + int'(b)) > 255;
        sr = sa + sb; v = (sr > 127) || (sr < -128);
      end
      3'b001: begin
        r = 8'((int'(a) - int'(b) + 256) % 256);
        c = a < b;
        sr = sa - sb; v = (sr > 127) || (sr < -128);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      default: r = a;
    endcase
    return {r, c, v};
  endfunction

  function automatic logic [15:0] ref_entry(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic [3:0] tag);
    logic [9:0] f;
    f = alu_fn(a, b, op);
    return {f[9:2], f[1], f[0], (f[9:2] == 8'h00), f[9], tag};
  endfunction

  // Behavioural 3-stage ALU: samples operands, result/c/v 2 edges later, z/n one after.
  logic [7:0] s_a, s_b;
  logic [2:0] s_op;
  logic [9:0] s_f;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a <= '0; s_b <= '0; s_op <= '0; s_f <= '0;
      alu_result <= '0; alu_c <= 1'b0; alu_v <= 1'b0; alu_z <= 1'b0; alu_n <= 1'b0;
    end else begin
      s_a <= alu_a; s_b <= alu_b; s_op <= alu_op;
      s_f <= alu_fn(s_a, s_b, s_op);
      {alu_result, alu_c, alu_v} <= s_f;
      alu_z <= (alu_result == 8'h00);
      alu_n <= alu_result[7];
    end
  end

  always @(posedge clk) begin
    rnd_bit <= 1'($urandom);
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back(ref_entry(in_a, in_b, in_op, in_tag));
      if (out_valid && out_ready)
        got_q.push_back({out_result, out_c, out_v, out_z, out_n, out_tag});
      if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
      if (out_valid) out_valid_seen++;
      if (dut.pv[4] && int'(dut.count) == DEPTH) begin
        full_push_seen++;
        n_total++;
        $display("FAIL full_push: count=%0d required < %0d", dut.count, DEPTH);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [3:0] tag);
    logic r;
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = in_ready;
      @(posedge clk); #1;
      if (r) return;
    end
    n_total++;
    $display("FAIL issue_timeout: tag=%0d not accepted within 200 cycles", tag);
  endtask

  task automatic drain(input int n);
    int i;
    for (i = 0; i < 300 && got_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    if (got_q.size() < n) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d results, required %0d", got_q.size(), n);
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_tag = 0; ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({alu_a, alu_b, alu_op} !== {8'h00, 8'h00, 3'b111})
      $display("FAIL reset_alu: got a=%h b=%h op=%b required 00 00 111", alu_a, alu_b, alu_op);
    else n_pass++;
    n_total++;
    if ({out_valid, busy, out_result, out_c, out_v, out_z, out_n, out_tag} !== 18'h0)
      $display("FAIL reset_out: got valid=%b busy=%b result=%h tag=%h required all 0",
               out_valid, busy, out_result, out_tag);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    clear_q();
    in_a = 8'h05; in_b = 8'h03; in_op = 3'b000; in_tag = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;                    // E0
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== (k == 5))
        $display("FAIL single_latency: after E%0d out_valid=%b required %b", k, out_valid, k == 5);
      else n_pass++;
    end
    n_total++;
    if ({out_result, out_c, out_z, out_n, out_tag} !== {8'h08, 3'b000, 4'd1})
      $display("FAIL single_data: got result=%h c=%b z=%b n=%b tag=%0d required 08 0 0 0 1",
               out_result, out_c, out_z, out_n, out_tag);
    else n_pass++;
    ready_mode = 1;
    @(posedge clk); #1;
    ready_mode = 0;
    n_total++;
    if ({busy, out_valid} !== 2'b00)
      $display("FAIL single_idle: got busy=%b out_valid=%b required 0 0", busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_q();
    ready_mode = 1;
    issue(8'hFF, 8'h01, 3'b000, 4'd2);
    issue(8'h03, 8'h05, 3'b001, 4'd3);
    in_valid = 1'b0;
    drain(2);
    n_total++;
    if (got_q.size() != 2 || got_q[0] !== {8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2})
      $display("FAIL b2b_first: got %h required %h", got_q.size() > 0 ? got_q[0] : 16'hx,
               {8'h00, 4'b1010, 4'd2});
    else n_pass++;
    n_total++;
    if (got_q.size() != 2 || got_q[1] !== {8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3})
      $display("FAIL b2b_second: got %h required %h", got_q.size() > 1 ? got_q[1] : 16'hx,
               {8'hFE, 4'b1001, 4'd3});
    else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_backpressure();
    int  acc;
    logic r;
    clear_q();
    ready_mode = 0;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom_range(0, 4));
      in_tag = 4'(i);
      r = in_ready;
      @(posedge clk); #1;
      if (r) acc++;
    end
    in_valid = 1'b0;
    n_total++;
    if (acc != DEPTH) $display("FAIL bp_accepts: got %0d required %0d", acc, DEPTH);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b required 0", in_ready);
    else n_pass++;
    ready_mode = 1;
    drain(DEPTH);
    @(posedge clk); #1;
    n_total++;
    if (got_q.size() != exp_q.size() || got_q != exp_q)
      $display("FAIL bp_order: got %0d entries required %0d matching model", got_q.size(), exp_q.size());
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_in_ready_back: got %b required 1", in_ready);
    else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_simul_push_pop();
    clear_q();
    ready_mode = 1;
    max_cnt = 0;
    for (int i = 0; i < 12; i++)
      issue(8'($urandom), 8'($urandom), 3'b100, 4'(i));
    in_valid = 1'b0;
    drain(12);
    n_total++;
    if (max_cnt > 1) $display("FAIL simul_count: got max count %0d required <= 1", max_cnt);
    else n_pass++;
    n_total++;
    if (got_q.size() != 12 || got_q != exp_q)
      $display("FAIL simul_order: got %0d entries required 12 matching model", got_q.size());
    else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    clear_q();
    ready_mode = 0;
    for (int i = 0; i < 3; i++) issue(8'(i + 1), 8'h10, 3'b000, 4'(i + 4));
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, busy, alu_op} !== {2'b00, 3'b111})
      $display("FAIL mid_reset_state: got valid=%b busy=%b alu_op=%b required 0 0 111",
               out_valid, busy, alu_op);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    out_valid_seen = 0;
    repeat (10) @(posedge clk);
    #1;
    n_total++;
    if (out_valid_seen != 0 || busy !== 1'b0)
      $display("FAIL mid_reset_quiet: got out_valid cycles=%0d busy=%b required 0 0",
               out_valid_seen, busy);
    else n_pass++;
    ready_mode = 1;
    issue(8'h40, 8'h40, 3'b000, 4'd9);
    in_valid = 1'b0;
    drain(1);
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== {8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9})
      $display("FAIL mid_reset_after: got %h required %h", got_q.size() > 0 ? got_q[0] : 16'hx,
               {8'h80, 4'b0101, 4'd9});
    else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_wrap();
    clear_q();
    ready_mode = 2;
    for (int i = 0; i < 10; i++)
      issue(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 4'(i + 6));
    in_valid = 1'b0;
    drain(10);
    n_total++;
    if (got_q.size() != 10 || got_q != exp_q)
      $display("FAIL wrap_order: got %0d entries required 10 matching model", got_q.size());
    else n_pass++;
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i][3:0] !== 4'(i + 6))
        $display("FAIL wrap_tag: index %0d got tag %0d required %0d", i, got_q[i][3:0], i + 6);
      else n_pass++;
    end
    n_total++;
    if (full_push_seen != 0) $display("FAIL wrap_full_push: got %0d events required 0", full_push_seen);
    else n_pass++;
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
